bp_be_stride_pf_gen: RTL and testbench

BP_BE_STRIDE_PF_GEN -- requirements
Module: bp_be_stride_pf_gen

---
 rtl/bp_be_pkg.sv | 31 +++
 rtl/bsg_counter_clear_up.sv | 21 ++
 rtl/bsg_dff_en.sv | 16 +
 rtl/bp_be_stride_pf_gen.sv | 136 +++++++++++++
 tb/tb_bp_be_stride_pf_gen.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bp_be_pkg.sv
// Shared back-end types: processor configuration table, stride prefetcher
// states and the default prefetch degree.
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  typedef struct packed {
    int vaddr_width;
    int page_offset_width;
  } bp_proc_param_s;

  typedef enum logic [1:0] {
    e_idle,
    e_arm,
    e_issue
  } bp_be_stride_pf_state_e;

  localparam int pf_degree_gp = 4;

  function automatic bp_proc_param_s bp_cfg_params(input bp_params_e cfg);
    bp_proc_param_s p;
    case (cfg)
      e_bp_default_cfg: p = '{vaddr_width: 39, page_offset_width: 12};
      default:          p = '{vaddr_width: 39, page_offset_width: 12};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; a clear and an up in one cycle yields 1.
module bsg_counter_clear_up #(
  parameter  int max_val_p    = 4,
  parameter  int init_val_p   = 0,
  localparam int ptr_width_lp = $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_o <= ptr_width_lp'(init_val_p);
    else if (clear_i | up_i)
      count_o <= (clear_i ? '0 : count_o) + ptr_width_lp'(up_i);
  end

endmodule

// File: rtl/bsg_dff_en.sv
// Plain enabled register; reset, when wanted, is folded into en_i/data_i.
module bsg_dff_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // NOTE: sequential state is always written with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (en_i) data_o <= data_i;
  end

endmodule

// File: rtl/bp_be_stride_pf_gen.sv
// Turns a confirmed load stride into up to pf_degree_p sequential prefetch
// requests, never leaving the page of the load that confirmed the stream.
module bp_be_stride_pf_gen
  import bp_be_pkg::*;
#(
  parameter  bp_params_e     bp_params_p          = e_bp_default_cfg,
  parameter  int             stride_width_p       = 8,
  parameter  int             pf_degree_p          = pf_degree_gp,
  localparam bp_proc_param_s proc_param_lp        = bp_cfg_params(bp_params_p),
  localparam int             vaddr_width_p        = proc_param_lp.vaddr_width,
  localparam int             page_offset_width_gp = proc_param_lp.page_offset_width
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      stride_v_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic                      start_discovery_i,
  input  logic                      confirm_discovery_i,
  input  logic                      flush_i,
  output logic                      pf_v_o,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  input  logic                      pf_ready_and_i,
  output logic                      busy_o
);

  localparam int ptr_width_lp  = $clog2(pf_degree_p + 1);
  localparam int page_width_lp = vaddr_width_p - page_offset_width_gp;

  bp_be_stride_pf_state_e state_q, state_d;

  logic [stride_width_p-1:0] stride_q;
  logic [vaddr_width_p-1:0]  pc_unused_q, next_addr_q, next_addr_d;
  logic [page_width_lp-1:0]  base_page_q;
  logic [ptr_width_lp-1:0]   count_lo;

  logic confirm, start, handshake, cross_page, last_issue;
  logic latch_stride, load_stream, advance;

  function automatic logic [vaddr_width_p-1:0] sext(input logic [stride_width_p-1:0] s);
    return {{(vaddr_width_p - stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  assign confirm    = stride_v_i & confirm_discovery_i;
  assign start      = stride_v_i & start_discovery_i & ~confirm_discovery_i;
  assign cross_page = next_addr_q[vaddr_width_p-1:page_offset_width_gp] != base_page_q;
  assign last_issue = count_lo == ptr_width_lp'(pf_degree_p - 1);

  assign pf_v_o    = ~reset_i & (state_q == e_issue) & ~cross_page;
  assign pf_addr_o = reset_i ? '0 : next_addr_q;
  assign busy_o    = ~reset_i & (state_q != e_idle);
  assign handshake = pf_v_o & pf_ready_and_i;

  // NOTE: every output of this block is defaulted first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    latch_stride = 1'b0;
    load_stream  = 1'b0;
    advance      = 1'b0;
    if (flush_i) begin
      state_d = e_idle;
      advance = handshake;
    end else if (confirm && (state_q != e_idle)) begin
      // A confirm restarts the stream; a same-cycle handshake is simply consumed.
      if (|stride_i) begin
        latch_stride = 1'b1;
        load_stream  = 1'b1;
        state_d      = e_issue;
      end else begin
        state_d = e_idle;
      end
    end else begin
      case (state_q)
        e_idle: if (start) begin
          latch_stride = 1'b1;
          state_d      = e_arm;
        end
        e_arm:   latch_stride = start;
        e_issue: begin
          advance = handshake;
          if ((handshake && last_issue) || cross_page) state_d = e_idle;
        end
        default: state_d = e_idle;
      endcase
    end
  end

  // NOTE: reset is synchronous and active-high, sampled on the clock edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= e_idle;
    else         state_q <= state_d;
  end

  assign next_addr_d = load_stream ? eff_addr_i + sext(stride_i)
                                   : next_addr_q + sext(stride_q);

  // NOTE: datapath flops have no reset pin; reset forces a zero load instead.
  bsg_dff_en #(.width_p(stride_width_p)) stride_reg (
    .clk_i (clk_i),
    .en_i  (reset_i | latch_stride),
    .data_i(reset_i ? '0 : stride_i),
    .data_o(stride_q)
  );

  // The PC identifies the stream for later consumers; nothing reads it here yet.
  bsg_dff_en #(.width_p(vaddr_width_p)) pc_reg (
    .clk_i (clk_i),
    .en_i  (reset_i | latch_stride),
    .data_i(reset_i ? '0 : pc_i),
    .data_o(pc_unused_q)
  );

  bsg_dff_en #(.width_p(vaddr_width_p)) next_addr_reg (
    .clk_i (clk_i),
    .en_i  (reset_i | load_stream | advance),
    .data_i(reset_i ? '0 : next_addr_d),
    .data_o(next_addr_q)
  );

  bsg_dff_en #(.width_p(page_width_lp)) base_page_reg (
    .clk_i (clk_i),
    .en_i  (reset_i | load_stream),
    .data_i(reset_i ? '0 : eff_addr_i[vaddr_width_p-1:page_offset_width_gp]),
    .data_o(base_page_q)
  );

  bsg_counter_clear_up #(.max_val_p(pf_degree_p), .init_val_p(0)) issue_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(load_stream),
    .up_i   (advance),
    .count_o(count_lo)
  );

endmodule

// File: tb/tb_bp_be_stride_pf_gen.sv
// Directed bench for the stride prefetch generator with hand-computed addresses.
module tb_bp_be_stride_pf_gen;
  import bp_be_pkg::*;

  localparam int vw_lp = 39;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             stride_v_i;
  logic [7:0]       stride_i;
  logic [vw_lp-1:0] pc_i;
  logic [vw_lp-1:0] eff_addr_i;
  logic             start_discovery_i;
  logic             confirm_discovery_i;
  logic             flush_i;
  logic             pf_v_o;
  logic [vw_lp-1:0] pf_addr_o;
  logic             pf_ready_and_i;
  logic             busy_o;

  int n_checks   = 0;
  int n_errors   = 0;
  int v_cycles   = 0;
  int cross_seen = 0;
  int v_mark;

  always #5 clk_i = ~clk_i;

  bp_be_stride_pf_gen #(
    .bp_params_p   (e_bp_default_cfg),
    .stride_width_p(8),
    .pf_degree_p   (4)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .stride_v_i         (stride_v_i),
    .stride_i           (stride_i),
    .pc_i               (pc_i),
    .eff_addr_i         (eff_addr_i),
    .start_discovery_i  (start_discovery_i),
    .confirm_discovery_i(confirm_discovery_i),
    .flush_i            (flush_i),
    .pf_v_o             (pf_v_o),
    .pf_addr_o          (pf_addr_o),
    .pf_ready_and_i     (pf_ready_and_i),
    .busy_o             (busy_o)
  );

  always @(negedge clk_i) begin
    if (pf_v_o) begin
      v_cycles++;
      if (pf_addr_o == 39'h1FF8) cross_seen++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_disc(input logic [7:0] s);
    stride_v_i        = 1'b1;
    start_discovery_i = 1'b1;
    stride_i          = s;
    pc_i              = 39'h0000_8000_0100;
    step();
    stride_v_i        = 1'b0;
    start_discovery_i = 1'b0;
    check("arm_busy", busy_o, 1'b1);
    check("arm_pf_v", pf_v_o, 1'b0);
  endtask

  task automatic confirm_disc(input logic [vw_lp-1:0] eff, input logic [7:0] s);
    stride_v_i          = 1'b1;
    confirm_discovery_i = 1'b1;
    eff_addr_i          = eff;
    stride_i            = s;
    step();
    stride_v_i          = 1'b0;
    confirm_discovery_i = 1'b0;
  endtask

  // Ready held high: expect base+stride*k for k = 1..n on consecutive cycles.
  task automatic run_stream(input string tag, input logic [vw_lp-1:0] base,
                            input logic [vw_lp-1:0] stride, input int n);
    for (int k = 1; k <= n; k++) begin
      check({tag, "_v"}, pf_v_o, 1'b1);
      check({tag, "_addr"}, pf_addr_o, base + stride * vw_lp'(k));
      step();
    end
    check({tag, "_end_v"}, pf_v_o, 1'b0);
    check({tag, "_end_busy"}, busy_o, 1'b0);
  endtask

  initial begin
    reset_i             = 1'b1;
    stride_v_i          = 1'b0;
    stride_i            = '0;
    pc_i                = '0;
    eff_addr_i          = '0;
    start_discovery_i   = 1'b0;
    confirm_discovery_i = 1'b0;
    flush_i             = 1'b0;
    pf_ready_and_i      = 1'b1;
    #1;
    check("rst_pf_v", pf_v_o, 1'b0);
    step();
    step();
    check("rst_pf_v_clk", pf_v_o, 1'b0);
    check("rst_addr", pf_addr_o, '0);
    check("rst_busy", busy_o, 1'b0);
    reset_i = 1'b0;
    step();
    check("idle_busy", busy_o, 1'b0);

    // Base stream
    start_disc(8'h40);
    confirm_disc(39'h1080, 8'h40);
    run_stream("base", 39'h1080, 39'h40, 4);

    // Back-pressure: 0x10C0 held while ready is low
    pf_ready_and_i = 1'b0;
    start_disc(8'h40);
    confirm_disc(39'h1080, 8'h40);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_v", pf_v_o, 1'b1);
      check("bp_hold_addr", pf_addr_o, 39'h10C0);
      step();
    end
    pf_ready_and_i = 1'b1;
    run_stream("bp", 39'h1080, 39'h40, 4);

    // Negative stride crossing below the page
    start_disc(8'hF8);
    confirm_disc(39'h2010, 8'hF8);
    check("neg_v0", pf_v_o, 1'b1);
    check("neg_addr0", pf_addr_o, 39'h2008);
    step();
    check("neg_v1", pf_v_o, 1'b1);
    check("neg_addr1", pf_addr_o, 39'h2000);
    step();
    check("xpage_drop_v", pf_v_o, 1'b0);
    check("xpage_busy", busy_o, 1'b1);
    step();
    check("xpage_idle", busy_o, 1'b0);
    check("xpage_never_shown", 64'(cross_seen), 64'd0);

    // Zero stride
    v_mark = v_cycles;
    start_disc(8'h40);
    confirm_disc(39'h4000, 8'h00);
    check("zero_busy", busy_o, 1'b0);
    step();
    step();
    check("zero_v", pf_v_o, 1'b0);
    check("zero_no_req", 64'(v_cycles - v_mark), 64'd0);

    // Flush after two handshakes
    start_disc(8'h40);
    confirm_disc(39'h1080, 8'h40);
    check("fl_addr0", pf_addr_o, 39'h10C0);
    step();
    check("fl_addr1", pf_addr_o, 39'h1100);
    step();
    check("fl_addr2", pf_addr_o, 39'h1140);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("fl_v", pf_v_o, 1'b0);
    check("fl_busy", busy_o, 1'b0);
    step();
    check("fl_v_stays", pf_v_o, 1'b0);

    // Confirm during issue restarts the stream and its count
    start_disc(8'h40);
    confirm_disc(39'h1080, 8'h40);
    check("rs_addr0", pf_addr_o, 39'h10C0);
    step();
    check("rs_addr1", pf_addr_o, 39'h1100);
    confirm_disc(39'h3000, 8'h10);
    run_stream("rs", 39'h3000, 39'h10, 4);

    // Reset mid-stream discards the stream
    start_disc(8'h40);
    confirm_disc(39'h5000, 8'h40);
    check("mr_addr0", pf_addr_o, 39'h5040);
    step();
    reset_i = 1'b1;
    #1;
    check("mr_v_comb", pf_v_o, 1'b0);
    step();
    check("mr_v", pf_v_o, 1'b0);
    check("mr_addr", pf_addr_o, '0);
    check("mr_busy", busy_o, 1'b0);
    reset_i = 1'b0;
    v_mark  = v_cycles;
    step();
    step();
    check("mr_after_busy", busy_o, 1'b0);
    check("mr_no_req", 64'(v_cycles - v_mark), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
